mult_issue_ctrl: RTL and testbench
==================================

// Module: mult_issue_ctrl
// PURPOSE
//  Upstream issue stage for the 32x32 shift-add multiplier core (ports clk, reset, X[63:0], Y[31:0], resultado[63:0]).
//  Accepts operand pairs over a valid/ready handshake and buffers them in a 2-entry FIFO.
//  Presents X/Y to the core, restarts it, times the fixed core latency, then returns the 64-bit product over valid/ready.
//  The core has no start/done pins; this block supplies both.
// PARAMETERS
//  WIDTH         32  operand width; X is 2*WIDTH, zero-extended
//  MULT_LATENCY  34  cycles from the end of mult_start until mult_resultado is final and stable
//  FIFO_DEPTH    2   operand-pair buffer entries (power of two)
// PORTS
//  clk             in   1        system clock, rising edge
//  reset           in   1        asynchronous, active-low; clears all state
//  in_valid        in   1        operand pair valid
//  in_ready        out  1        FIFO not full
//  in_a            in   WIDTH    multiplicand
//  in_b            in   WIDTH    multiplier
//  mult_start      out  1        one-cycle restart pulse to the core FSM
//  mult_x          out  2*WIDTH  {WIDTH'b0, a} to core X
//  mult_y          out  WIDTH    b to core Y
//  mult_resultado  in   2*WIDTH  core product
//  out_valid       out  1        product valid
//  out_ready       in   1        consumer accepts product
//  out_product     out  2*WIDTH  registered product
//  busy            out  1        FSM != IDLE or FIFO not empty
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, in_ready=1, FSM=IDLE, mult_start=0, mult_x/mult_y=0, out_valid=0, out_product=0, counter=0.
//  Input: push on in_valid&in_ready; in_ready=!full, driven from a registered count. Data is ignored when not ready.
//  FIFO: push and pop in the same cycle are legal. When full, push+pop is not legal because in_ready=0. Pointers wrap modulo FIFO_DEPTH.
//  FSM states:
//   IDLE    -> ISSUE when FIFO not empty. Pops the head into the mult_x/mult_y registers.
//   ISSUE   mult_start=1 for exactly one cycle; load cnt=MULT_LATENCY-1; -> WAIT
//   WAIT    cnt decrements each cycle. At cnt==0: if !out_valid|out_ready -> CAPTURE, else stay in WAIT with cnt held at 0 (stall).
//   CAPTURE out_product<=mult_resultado, out_valid<=1; -> IDLE
//  mult_x/mult_y are held stable from the IDLE pop until the next pop; the core output stays stable while X/Y are unchanged.
//  Output: out_valid clears on out_valid&out_ready unless CAPTURE sets it in that same cycle. In that case it stays 1 with the new data; no product is lost.
//  Latency: idle and empty, handshake at edge 0 -> IDLE sees data in cycle 1 -> ISSUE in cycle 2 -> out_valid in cycle MULT_LATENCY+4 (38 at default).
//  Throughput: one product per MULT_LATENCY+3 cycles when out_ready is tied high.
//  Arithmetic: no width growth inside the block; the product is passed through unmodified.
//  Reset mid-operation (any state): everything returns to reset values immediately; the in-flight product and buffered pairs are dropped; no mult_start glitch.
//  mult_start is never asserted during or in the first cycle after reset release.
// STRUCTURE
//  Shared include mult_defs.vh: FSM state encodings (IDLE/ISSUE/WAIT/CAPTURE), WIDTH and MULT_LATENCY defaults. The core and this block both use it.
//  One sub-module, op_fifo: parameterised 2*WIDTH-bit sync FIFO with full/empty from a registered count.
//  Counter width: $clog2(MULT_LATENCY).
// TESTING
//  1. Single op: a=3, b=5, out_ready=1 -> mult_x=64'h3, mult_y=5, one mult_start pulse; out_product=15 with out_valid in cycle 38 for one cycle.
//  2. Max operands: a=b=32'hFFFF_FFFF -> out_product=64'hFFFF_FFFE_0000_0001; a=0, b=7 -> 0.
//  3. Back-to-back: push 3 pairs with in_valid held -> in_ready drops after 2 are buffered. The 3rd is accepted after the first pop. Products come out in order, 37 cycles apart.
//  4. Backpressure: out_ready=0 with 2 pairs queued -> first product held; FSM stalls in WAIT; mult_x unchanged. On out_ready=1 the second product follows next cycle, value correct.
//  5. Reset mid-WAIT (cnt=10): reset low 1 cycle -> out_valid=0, busy=0, in_ready=1. A new op afterwards completes with the correct product and normal latency.
//  6. Simultaneous push/pop: in_valid=1 in the cycle IDLE pops, FIFO count=1 -> count stays 1; no data is duplicated or lost (scoreboard).

Source files
------------

// File: rtl/mult_issue_ctrl_pkg.sv
// mult_issue_ctrl_pkg: shared defaults and FSM state encoding for the multiplier issue stage
//   WIDTH_DEF          operand width
//   MULT_LATENCY_DEF   cycles from the end of mult_start until the core product is final
//   FIFO_DEPTH_DEF     operand-pair buffer entries (power of two)
//   state_e            issue FSM states
package mult_issue_ctrl_pkg;
    localparam int WIDTH_DEF        = 32;
    localparam int MULT_LATENCY_DEF = 34;
    localparam int FIFO_DEPTH_DEF   = 2;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_e;
endpackage

// File: rtl/mult_issue_ctrl_op_fifo.sv
// op_fifo: synchronous show-ahead FIFO with full/empty decoded from a registered count
//   clk      system clock, rising edge
//   reset    asynchronous, active-low
//   push_i   write request, ignored when full_o
//   din_i    write data
//   pop_i    read request, ignored when empty_o
//   dout_o   head entry
//   full_o   count == DEPTH
//   empty_o  count == 0
module op_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == FULL_CNT;
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = (do_push && !do_pop) ? cnt_q + 1'b1 :
                (do_pop && !do_push) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue stage for the fixed-latency shift-add multiplier core
//   clk, reset          clock; asynchronous active-low reset
//   in_valid/in_ready   operand handshake, in_a/in_b operands buffered in op_fifo
//   mult_start          one-cycle restart pulse to the core
//   mult_x/mult_y       held operands to the core ({0,a}, b)
//   mult_resultado      core product, sampled once the latency has elapsed
//   out_valid/out_ready product handshake, out_product registered result
//   busy                FSM active or operands pending
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int MULT_LATENCY = MULT_LATENCY_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mult_start,
    output logic [2*WIDTH-1:0] mult_x,
    output logic [WIDTH-1:0]   mult_y,
    input  logic [2*WIDTH-1:0] mult_resultado,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);
    localparam int CW = $clog2(MULT_LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_LATENCY - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               ov_q, ov_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] head;
    logic               fifo_full, fifo_empty, pop, out_free;

    op_fifo #(.DW(2*WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .din_i   ({in_a, in_b}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign pop         = state_q == IDLE && !fifo_empty;
    // A new product may be captured only if the output register is free or drains this cycle.
    assign out_free    = !ov_q || out_ready;
    assign mult_start  = state_q == ISSUE;
    assign mult_x      = {{WIDTH{1'b0}}, a_q};
    assign mult_y      = b_q;
    assign out_valid   = ov_q;
    assign out_product = prod_q;
    assign busy        = state_q != IDLE || !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    state_d = fifo_empty ? IDLE : ISSUE;
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            // cnt sticks at zero while the output register is still occupied.
            WAIT: begin
                cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                state_d = (cnt_q == '0 && out_free) ? CAPTURE : WAIT;
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        a_d    = pop ? head[2*WIDTH-1:WIDTH] : a_q;
        b_d    = pop ? head[WIDTH-1:0] : b_q;
        // A capture in the same cycle as a drain wins, so the new product is kept.
        ov_d   = (state_q == CAPTURE) ? 1'b1 : (ov_q && out_ready) ? 1'b0 : ov_q;
        prod_d = (state_q == CAPTURE) ? mult_resultado : prod_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ov_q    <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ov_q    <= ov_d;
            prod_q  <= prod_d;
        end
    end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: randomized and directed bench for mult_issue_ctrl against a transaction-level model
module tb_mult_issue_ctrl;
    localparam int L  = 34;
    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        mult_start;
    logic [63:0] mult_x;
    logic [31:0] mult_y;
    logic [63:0] mult_resultado = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_product;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mult_issue_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .mult_start     (mult_start),
        .mult_x         (mult_x),
        .mult_y         (mult_y),
        .mult_resultado (mult_resultado),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_product    (out_product),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Core stand-in: garbage until L cycles after the restart pulse, then the true product.
    int unsigned core_age = 1000;
    always @(negedge clk) begin
        if (mult_start) core_age = 0;
        else if (core_age < 1000) core_age++;
        mult_resultado = (core_age >= L) ? 64'(mult_x[31:0]) * 64'(mult_y) : {$urandom, $urandom};
    end

    // Transaction model: queue of pairs, one job with an age counted from its restart cycle.
    typedef struct packed { logic [31:0] a; logic [31:0] b; } pair_t;
    pair_t       mq[$];
    bit          m_job = 0;
    int          m_age = 0;
    logic [31:0] m_ja = '0, m_jb = '0;
    bit          m_ov = 0;
    logic [63:0] m_prod = '0, m_x = '0;
    logic [31:0] m_y = '0;
    bit          m_push, m_cons, m_free;
    int          n_in = 0, n_out = 0, n_drop = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_drop += mq.size() + int'(m_job) + int'(m_ov);
            mq.delete();
            m_job = 0; m_age = 0; m_ov = 0; m_prod = '0; m_x = '0; m_y = '0;
        end else begin
            m_push = in_valid && mq.size() < FD;
            m_cons = m_ov && out_ready;
            m_free = !m_ov || out_ready;
            if (m_cons) begin
                m_ov = 0;
                n_out++;
            end
            if (m_job) begin
                if (m_age == L + 1) begin
                    m_ov   = 1;
                    m_prod = 64'(m_ja) * 64'(m_jb);
                    m_job  = 0;
                end else if (m_age < L || m_free) m_age++;
            end else if (mq.size() > 0) begin
                m_ja = mq[0].a;
                m_jb = mq[0].b;
                void'(mq.pop_front());
                m_job = 1; m_age = 0;
                m_x = {32'b0, m_ja}; m_y = m_jb;
            end
            if (m_push) begin
                mq.push_back('{a: in_a, b: in_b});
                n_in++;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(mq.size() < FD));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_product", out_product, m_prod);
        chk("mult_start", 64'(mult_start), 64'(m_job && m_age == 0));
        chk("busy", 64'(busy), 64'(m_job || mq.size() > 0));
        chk("mult_x", mult_x, m_x);
        chk("mult_y", 64'(mult_y), 64'(m_y));
    end

    // All tasks start and end at posedge+1.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        int  n = 0;
        bit  acc = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 200);
        #1 in_valid = 1'b0;
        chk("push_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", 64'(busy || out_valid), 64'd0);
    endtask

    task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input string tag);
        int first = 0, pulses = 0, vcyc = 0;
        logic [63:0] got = '0;
        wait_idle();
        push_pair(a, b);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (mult_start) pulses++;
            if (k == 3) chk({tag, "_mult_x"}, mult_x, {32'b0, a});
            if (out_valid) begin
                vcyc++;
                if (first == 0) begin
                    first = k;
                    got = out_product;
                end
            end
        end
        chk({tag, "_latency"}, 64'(first), 64'd38);
        chk({tag, "_product"}, got, exp);
        chk({tag, "_start_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_valid_cycles"}, 64'(vcyc), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int t[3];
        logic [63:0] p[3];
        int nv, first;
        logic [63:0] got;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mult_x", mult_x, 64'd0);
        chk("rst_out_product", out_product, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_single(32'd3, 32'd5, 64'd15, "t1");
        run_single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "t2max");
        run_single(32'd0, 32'd7, 64'd0, "t2zero");

        // back-to-back with in_valid held; second push coincides with the first pop
        wait_idle();
        push_pair(32'd1, 32'd2);
        push_pair(32'd3, 32'd4);
        chk("t6_ready_after_pushpop", 64'(in_ready), 64'd1);
        push_pair(32'd5, 32'd6);
        chk("t3_ready_full", 64'(in_ready), 64'd0);
        nv = 0;
        for (int k = 1; k <= 150 && nv < 3; k++) begin
            @(negedge clk);
            if (out_valid) begin
                t[nv] = k;
                p[nv] = out_product;
                nv++;
            end
        end
        chk("t3_count", 64'(nv), 64'd3);
        chk("t3_first_time", 64'(t[0]), 64'd36);
        chk("t3_gap1", 64'(t[1] - t[0]), 64'd37);
        chk("t3_gap2", 64'(t[2] - t[1]), 64'd37);
        chk("t3_p0", p[0], 64'd2);
        chk("t3_p1", p[1], 64'd12);
        chk("t3_p2", p[2], 64'd30);
        @(posedge clk); #1;

        // backpressure
        wait_idle();
        out_ready = 1'b0;
        push_pair(32'd7, 32'd9);
        push_pair(32'h1_0000, 32'h1_0000);
        repeat (100) begin @(posedge clk); #1; end
        chk("t4_hold_valid", 64'(out_valid), 64'd1);
        chk("t4_hold_product", out_product, 64'd63);
        chk("t4_x_stable", mult_x, 64'h1_0000);
        chk("t4_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        first = 0;
        got = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid && first == 0) begin
                first = k;
                got = out_product;
            end
        end
        chk("t4_second_delay", 64'(first), 64'd2);
        chk("t4_second_product", got, 64'h1_0000_0000);
        @(posedge clk); #1;

        // reset while waiting with cnt == 10
        wait_idle();
        push_pair(32'd20, 32'd30);
        repeat (26) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_mult_start", 64'(mult_start), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_single(32'd11, 32'd13, 64'd143, "t5_after");

        // randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 3) == 0;
            in_a      = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
            in_b      = ($urandom % 8 == 0) ? 32'h0 : $urandom;
            out_ready = ($urandom % 4) != 0;
            if ($urandom % 1500 == 0) begin
                reset = 1'b0;
                #3 reset = 1'b1;
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("scoreboard_balance", 64'(n_out + n_drop), 64'(n_in));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
